// File: rtl/regbank_write_arbiter.sv
// rtl/regbank_write_arbiter.sv - 4 x WIDTH register bank with a round-robin arbitrated shared write port
//
// Purpose: lets four datapath units share the single write path of a
// four-register bank. One write commits per cycle, chosen round-robin,
// and two combinational read ports expose the register contents.
//
// Optional build macro: ARB_LOCK_EN adds the lock[3:0] input. A winner
// committing with its lock bit set becomes lock owner and keeps the bank
// to itself, one write per cycle, until it commits with lock=0 or drops req.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   req[3:0]     per-requester write request (level, held until ack)
//   wr_addr[7:0] requester i target register at [2i+1:2i]
//   wr_data      requester i data at [(i+1)*WIDTH-1:i*WIDTH]
//   ack[3:0]     one-cycle pulse, write of requester i committed
//   grant_valid  a write committed at the last edge
//   grant_id     requester index of that write
//   rd_addr_a/b  read port indices
//   rd_data_a/b  combinational read data
//   lock[3:0]    (ARB_LOCK_EN only) per-requester bank lock request

module regbank_write_arbiter #(
    parameter int                WIDTH     = 16,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req,
    input  logic [7:0]           wr_addr,
    input  logic [4*WIDTH-1:0]   wr_data,
`ifdef ARB_LOCK_EN
    input  logic [3:0]           lock,
`endif
    output logic [3:0]           ack,
    output logic                 grant_valid,
    output logic [1:0]           grant_id,
    input  logic [1:0]           rd_addr_a,
    output logic [WIDTH-1:0]     rd_data_a,
    input  logic [1:0]           rd_addr_b,
    output logic [WIDTH-1:0]     rd_data_b
);

    logic [WIDTH-1:0] regs     [4];
    logic [1:0]       req_addr [4];
    logic [WIDTH-1:0] req_data [4];

    logic [1:0] ptr;
    logic [1:0] scan_start;
    logic [3:0] elig;
    logic       found;
    logic [1:0] winner;
    logic [1:0] idx;

`ifdef ARB_LOCK_EN
    logic       own_valid;
    logic [1:0] own_id;
`endif

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_unpack
            assign req_addr[g] = wr_addr[2*g +: 2];
            assign req_data[g] = wr_data[g*WIDTH +: WIDTH];
        end
    endgenerate

    // Arbitration. The ack mask keeps a requester whose req is still high
    // during its ack cycle from being written twice.
    always_comb begin
        elig       = req & ~ack;
        scan_start = ptr;
`ifdef ARB_LOCK_EN
        if (own_valid) begin
            if (req[own_id] && lock[own_id]) begin
                // Owner keeps the bank and bypasses its own ack mask.
                elig = 4'(1) << own_id;
            end else begin
                // Ownership ends this cycle; round-robin resumes after owner.
                scan_start = own_id + 2'd1;
            end
        end
`endif
        found  = 1'b0;
        winner = 2'd0;
        idx    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = scan_start + 2'(k);
            if (!found && elig[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= RESET_VAL;
            end
            ack         <= 4'd0;
            grant_valid <= 1'b0;
            grant_id    <= 2'd0;
            ptr         <= 2'd0;
`ifdef ARB_LOCK_EN
            own_valid   <= 1'b0;
            own_id      <= 2'd0;
`endif
        end else begin
            if (found) begin
                regs[req_addr[winner]] <= req_data[winner];
                ack         <= 4'(1) << winner;
                grant_valid <= 1'b1;
                grant_id    <= winner;
`ifdef ARB_LOCK_EN
                own_valid   <= lock[winner];
                own_id      <= winner;
                if (!lock[winner]) begin
                    ptr <= winner + 2'd1;
                end
`else
                ptr         <= winner + 2'd1;
`endif
            end else begin
                ack         <= 4'd0;
                grant_valid <= 1'b0;
`ifdef ARB_LOCK_EN
                // Owner dropped req with nobody else waiting: the pointer was
                // frozen during the lock, so move it past the owner now.
                if (own_valid) begin
                    ptr <= own_id + 2'd1;
                end
                own_valid   <= 1'b0;
`endif
            end
        end
    end

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// tb/tb_regbank_write_arbiter.sv - directed self-checking bench for regbank_write_arbiter
module tb_regbank_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  wr_addr;
    logic [63:0] wr_data;
    logic [3:0]  ack;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic [1:0]  rd_addr_a;
    logic [15:0] rd_data_a;
    logic [1:0]  rd_addr_b;
    logic [15:0] rd_data_b;
`ifdef ARB_LOCK_EN
    logic [3:0]  lock;
`endif

    int checks = 0;
    int errors = 0;

    regbank_write_arbiter #(.WIDTH(16), .RESET_VAL(16'h0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
`ifdef ARB_LOCK_EN
        .lock        (lock),
`endif
        .ack         (ack),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .rd_addr_a   (rd_addr_a),
        .rd_data_a   (rd_data_a),
        .rd_addr_b   (rd_addr_b),
        .rd_data_b   (rd_data_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] a, input logic [15:0] d);
        wr_addr[2*i +: 2]  = a;
        wr_data[16*i +: 16] = d;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b expected 0000", ack); end
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_gv: got %b expected 0", grant_valid); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_gid: got %0d expected 0", grant_id); end
        for (int k = 0; k < 4; k++) begin
            rd_addr_a = 2'(k);
            #1;
            checks++; if (rd_data_a !== 16'h0000) begin errors++; $display("FAIL reset_reg%0d: got %h expected 0000", k, rd_data_a); end
        end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_single_write();
        set_req(0, 2'd2, 16'hBEEF);
        req = 4'b0001;
        rd_addr_a = 2'd2;
        #1;
        checks++; if (rd_data_a !== 16'h0000) begin errors++; $display("FAIL single_pre: got %h expected 0000", rd_data_a); end
        tick();
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL single_ack: got %b expected 0001", ack); end
        checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL single_grant: got gv=%b id=%0d expected gv=1 id=0", grant_valid, grant_id); end
        checks++; if (rd_data_a !== 16'hBEEF) begin errors++; $display("FAIL single_read: got %h expected beef", rd_data_a); end
        req = 4'b0000;
        tick();
        checks++; if (ack !== 4'b0000 || grant_valid !== 1'b0) begin errors++; $display("FAIL single_pulse: got ack=%b gv=%b expected 0000/0", ack, grant_valid); end
    endtask

    task automatic test_same_address();
        // ptr is 1; one write by requester 1 moves it to 2
        set_req(1, 2'd3, 16'h00D1);
        req = 4'b0010;
        tick();
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL race_setup_ack: got %b expected 0010", ack); end
        req = 4'b0000;
        tick();
        set_req(1, 2'd1, 16'hAAAA);
        set_req(2, 2'd1, 16'h5555);
        req = 4'b0110;
        rd_addr_b = 2'd1;
        #1;
        checks++; if (rd_data_b !== 16'h0000) begin errors++; $display("FAIL race_read0: got %h expected 0000", rd_data_b); end
        tick();
        checks++; if (ack !== 4'b0100 || rd_data_b !== 16'h5555) begin errors++; $display("FAIL race_first: got ack=%b reg1=%h expected 0100/5555", ack, rd_data_b); end
        req = 4'b0010;
        tick();
        checks++; if (ack !== 4'b0010 || rd_data_b !== 16'hAAAA) begin errors++; $display("FAIL race_second: got ack=%b reg1=%h expected 0010/aaaa", ack, rd_data_b); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_fairness_wrap();
        logic [1:0]  exp_id;
        logic [15:0] n0;
        logic [15:0] n3;
        // ptr is 2; one write by requester 2 moves it to 3
        set_req(2, 2'd0, 16'h0000);
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        n0 = 16'h0A00;
        n3 = 16'h3A00;
        set_req(0, 2'd0, n0);
        set_req(3, 2'd2, n3);
        req = 4'b1001;
        exp_id = 2'd3;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++; if (ack !== (4'(1) << exp_id) || grant_id !== exp_id) begin errors++; $display("FAIL fair_cycle%0d: got ack=%b id=%0d expected id=%0d", c, ack, grant_id, exp_id); end
            if (exp_id == 2'd3) begin
                n3 = n3 + 16'd1;
                set_req(3, 2'd2, n3);
                exp_id = 2'd0;
            end else begin
                n0 = n0 + 16'd1;
                set_req(0, 2'd0, n0);
                exp_id = 2'd3;
            end
        end
        req = 4'b0000;
        rd_addr_a = 2'd0;
        rd_addr_b = 2'd2;
        #1;
        checks++; if (rd_data_a !== 16'h0A02 || rd_data_b !== 16'h3A02) begin errors++; $display("FAIL fair_regs: got reg0=%h reg2=%h expected 0a02/3a02", rd_data_a, rd_data_b); end
        tick();
    endtask

    task automatic test_reset_midrun();
        set_req(1, 2'd1, 16'h1234);
        req = 4'b0010;
        tick();
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL rstmid_pre_ack: got %b expected 0010", ack); end
        #1;
        rst = 1'b0;
        #1;
        checks++; if (ack !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin errors++; $display("FAIL rstmid_outputs: got ack=%b gv=%b id=%0d expected 0000/0/0", ack, grant_valid, grant_id); end
        for (int k = 0; k < 4; k++) begin
            rd_addr_a = 2'(k);
            #1;
            checks++; if (rd_data_a !== 16'h0000) begin errors++; $display("FAIL rstmid_reg%0d: got %h expected 0000", k, rd_data_a); end
        end
        tick();
        rd_addr_a = 2'd1;
        #1;
        checks++; if (rd_data_a !== 16'h0000 || ack !== 4'b0000) begin errors++; $display("FAIL rstmid_held: got reg1=%h ack=%b expected 0000/0000", rd_data_a, ack); end
        req = 4'b0000;
        rst = 1'b1;
    endtask

    task automatic test_all_four();
        set_req(0, 2'd3, 16'h1111);
        set_req(1, 2'd2, 16'h2222);
        set_req(2, 2'd1, 16'h3333);
        set_req(3, 2'd0, 16'h4444);
        req = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (ack !== (4'(1) << c)) begin errors++; $display("FAIL all4_ack%0d: got %b expected %b", c, ack, 4'(1) << c); end
            req = req & ~ack;
        end
        rd_addr_a = 2'd0;
        rd_addr_b = 2'd3;
        #1;
        checks++; if (rd_data_a !== 16'h4444 || rd_data_b !== 16'h1111) begin errors++; $display("FAIL all4_regs: got reg0=%h reg3=%h expected 4444/1111", rd_data_a, rd_data_b); end
        tick();
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        set_req(2, 2'd1, 16'hC001);
        set_req(0, 2'd0, 16'h0A0A);
        lock = 4'b0100;
        req  = 4'b0100;
        tick();
        checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL lock_ack0: got %b expected 0100", ack); end
        req = 4'b0101;
        set_req(2, 2'd1, 16'hC002);
        tick();
        checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL lock_ack1: got %b expected 0100", ack); end
        set_req(2, 2'd1, 16'hC003);
        tick();
        checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL lock_ack2: got %b expected 0100", ack); end
        req  = 4'b0001;
        lock = 4'b0000;
        tick();
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL lock_release: got %b expected 0001", ack); end
        req = 4'b0000;
        rd_addr_a = 2'd1;
        rd_addr_b = 2'd0;
        #1;
        checks++; if (rd_data_a !== 16'hC003 || rd_data_b !== 16'h0A0A) begin errors++; $display("FAIL lock_regs: got reg1=%h reg0=%h expected c003/0a0a", rd_data_a, rd_data_b); end
        tick();
    endtask
`endif

    initial begin
        rst       = 1'b0;
        req       = 4'b0000;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr_a = 2'd0;
        rd_addr_b = 2'd0;
`ifdef ARB_LOCK_EN
        lock      = 4'b0000;
`endif
        test_reset();
        test_single_write();
        test_same_address();
        test_fairness_wrap();
        test_reset_midrun();
        test_all_four();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regbank_write_arbiter.md
Name: regbank_write_arbiter

Overview:
- 4-entry × WIDTH register bank with one shared write port, arbitrated round-robin among 4 requesters, plus two combinational read ports.
- Generates the per-register store strobes internally (2→4 decode of the winning address).
- Sits between the datapath units and the general register bank, so several units can share the bank's single write path without collisions.

Parameters:
WIDTH, 16, data width of each register and of each write/read port
RESET_VAL, 0, value loaded into every register on reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
req  in  4  req[i]: requester i wants one write; level, held until ack[i]
wr_addr  in  8  requester i target register index at bits [2i+1:2i]
wr_data  in  4*WIDTH  requester i write data at bits [(i+1)*WIDTH-1 : i*WIDTH]
ack  out  4  ack[i]: registered one-cycle pulse, write of requester i committed
grant_valid  out  1  registered; a write was committed at the last edge
grant_id  out  2  registered; requester index of that write
rd_addr_a  in  2  read port A index
rd_data_a  out  WIDTH  combinational read of register rd_addr_a
rd_addr_b  in  2  read port B index
rd_data_b  out  WIDTH  combinational read of register rd_addr_b

Behaviour:
- Reset (rst=0, async): all 4 registers = RESET_VAL; ack=0; grant_valid=0; grant_id=0; priority pointer ptr=0. Reset takes effect immediately, including mid-write; no write is committed while rst=0.
- Eligibility each cycle: elig[i] = req[i] & ~ack[i]. This masks the requester whose ack is currently high, so a still-high req in its ack cycle does not cause a double write.
- Arbitration (combinational): winner = first eligible index scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- Commit at rising edge when any elig bit is set:
  - reg[wr_addr[winner]] <= wr_data[winner]
  - ack <= one-hot(winner)
  - grant_valid <= 1; grant_id <= winner
  - ptr <= winner+1 (mod 4, wraps 3→0)
- No eligible requester at the edge: ack <= 0; grant_valid <= 0; grant_id and ptr hold.
- Latency: a request seen at edge N commits at edge N, and ack is visible during the following cycle.
  - Throughput: one write per cycle overall.
  - A single requester gets at most one write every 2 cycles (ack mask).
- Requester rules:
  - wr_addr/wr_data must stay stable while req is high and ack is low.
  - On seeing ack, drop req or present new data; new data is eligible the cycle after ack.
- Reads are combinational from register state. Reading the register being written returns the old value before the edge and the new value after it; there is no bypass.
- Several requesters targeting the same register: they are serialized in arbitration order, and the last committed value wins.
- No other state and no error outputs.

Optional Feature:
Macro ARB_LOCK_EN.
- Defined:
  - Extra input port lock (4 bits).
  - If the winner has lock[winner]=1 at commit, ptr is not advanced and the lock owner is marked.
  - While the lock owner holds lock=1, only it is eligible, and its ack mask is ignored, giving back-to-back writes every cycle.
  - Ownership is released the first cycle the owner commits with lock=0 or drops req; normal round-robin then resumes from owner+1.
  - Reset clears ownership.
- Undefined: no lock port; pure round-robin as above.

Test Plan:
1. Reset: drive rst=0 mid-run with ack=0010 → ack=0, grant_valid=0, all registers read 0x0000 immediately. Release rst → first grant goes to requester 0 when all 4 request.
2. Single write: req=0001, wr_addr[1:0]=2, data 0xBEEF → at the next edge reg2=0xBEEF; ack=0001 for exactly 1 cycle; grant_id=0; rd_addr_a=2 gives 0xBEEF.
3. All four request at once, addresses 3,2,1,0, data 0x1111..0x4444 → acks 0001,0010,0100,1000 on 4 consecutive cycles; final reg0=0x4444 and reg3=0x1111.
4. Fairness and wrap: req0 and req3 held high, each re-presenting new data after every ack, starting with ptr=3 → grant order 3,0,3,0…; no requester is ever acked twice within 2 cycles.
5. Same-address race: req1 (0xAAAA→reg1) and req2 (0x5555→reg1) asserted together with ptr=2 → commit order 2 then 1, final reg1=0xAAAA. Read port B on reg1 shows 0x0000 → 0x5555 → 0xAAAA.
6. ARB_LOCK_EN: req2 with lock=1 for 3 writes while req0 pends → acks 0100,0100,0100 on consecutive cycles, then 0001 after lock drops.
